// File: rtl/vga_pattern_gen.sv
// Test-pattern generator downstream of the HS/VS timing stage: recovers pixel position from sync
// edges and emits RGB/DE re-timed to match HS_OUT/VS_OUT (3-clock pipeline).
module vga_pattern_gen #(
    parameter int unsigned H_SYNC    = 120,
    parameter int unsigned H_BP      = 64,
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 23,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned BAR_W     = 100,
    parameter int unsigned H_TIMEOUT = 2047
) (
    input  logic       PIX_CLK,
    input  logic       RST,
    input  logic       HS,
    input  logic       VS,
    input  logic [1:0] MODE,
    output logic       HS_OUT,
    output logic       VS_OUT,
    output logic       DE,
    output logic [3:0] RED,
    output logic [3:0] GREEN,
    output logic [3:0] BLUE,
    output logic       LOCKED
);

    localparam logic [10:0] H_START  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END    = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] H_TO     = 11'(H_TIMEOUT);
    localparam logic [9:0]  V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  BAR_LAST = 10'(BAR_W - 1);

    typedef enum logic [1:0] {StUnlocked, StWaitVs, StLocked} state_e;

    state_e      state_q, state_d;
    logic        hs_d, vs_d, hs_p2, vs_p2;
    logic        hs_rise, vs_rise;
    logic [10:0] hcnt_q;
    logic [9:0]  vcnt_q;
    logic [1:0]  mode_q;
    logic        h_act, v_act;
    logic        de1_q, h_act_q;
    logic [9:0]  x_q, y_q;
    logic [9:0]  bar_px_q;
    logic [2:0]  bar_idx_q;
    logic [11:0] pix_rgb;

    assign hs_rise = HS & ~hs_d;
    assign vs_rise = VS & ~vs_d;
    assign h_act   = (hcnt_q >= H_START) && (hcnt_q < H_END);
    assign v_act   = (vcnt_q >= V_START) && (vcnt_q < V_END);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StUnlocked: if (hs_rise) state_d = StWaitVs;
            StWaitVs:   if (vs_rise) state_d = StLocked;
            StLocked:   if (hcnt_q == H_TO) state_d = StUnlocked;
            default:    state_d = StUnlocked;
        endcase
    end

    always_ff @(posedge PIX_CLK) begin
        if (RST) begin
            state_q <= StUnlocked;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pix_rgb = 12'h000;
        case (mode_q)
            2'd0: begin
                case (bar_idx_q)
                    3'd0:    pix_rgb = 12'hFFF;
                    3'd1:    pix_rgb = 12'hFF0;
                    3'd2:    pix_rgb = 12'h0FF;
                    3'd3:    pix_rgb = 12'h0F0;
                    3'd4:    pix_rgb = 12'hF0F;
                    3'd5:    pix_rgb = 12'hF00;
                    3'd6:    pix_rgb = 12'h00F;
                    default: pix_rgb = 12'h000;
                endcase
            end
            2'd1: pix_rgb = (x_q[5] ^ y_q[5]) ? 12'h000 : 12'hFFF;
            2'd2: pix_rgb = {x_q[9:6], x_q[9:6], x_q[9:6]};
            default: begin
                if ((x_q == 10'd0) || (x_q == X_LAST) || (y_q == 10'd0) || (y_q == Y_LAST)) begin
                    pix_rgb = 12'hFFF;
                end
            end
        endcase
    end

    always_ff @(posedge PIX_CLK) begin
        if (RST) begin
            hs_d      <= 1'b0;
            vs_d      <= 1'b0;
            hs_p2     <= 1'b0;
            vs_p2     <= 1'b0;
            HS_OUT    <= 1'b0;
            VS_OUT    <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            mode_q    <= '0;
            de1_q     <= 1'b0;
            h_act_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            DE        <= 1'b0;
            RED       <= '0;
            GREEN     <= '0;
            BLUE      <= '0;
            LOCKED    <= 1'b0;
        end else begin
            // hs_d/vs_d double as the first tap of the 3-clock sync delay line
            hs_d   <= HS;
            vs_d   <= VS;
            hs_p2  <= hs_d;
            vs_p2  <= vs_d;
            HS_OUT <= hs_p2;
            VS_OUT <= vs_p2;

            if (hs_rise) begin
                hcnt_q <= '0;
            end else if (hcnt_q != H_TO) begin
                hcnt_q <= hcnt_q + 11'd1;
            end

            if (vs_rise) begin
                vcnt_q <= '0;
            end else if (hs_rise && (vcnt_q != 10'h3FF)) begin
                vcnt_q <= vcnt_q + 10'd1;
            end

            if (vs_rise) begin
                mode_q <= MODE;
            end

            de1_q   <= (state_q == StLocked) && h_act && v_act;
            h_act_q <= h_act;
            x_q     <= 10'(hcnt_q - H_START);
            y_q     <= vcnt_q - V_START;

            // Bar position restarts on the first active pixel of every line
            if (h_act && h_act_q) begin
                if (bar_px_q == BAR_LAST) begin
                    bar_px_q  <= '0;
                    bar_idx_q <= bar_idx_q + 3'd1;
                end else begin
                    bar_px_q <= bar_px_q + 10'd1;
                end
            end else begin
                bar_px_q  <= '0;
                bar_idx_q <= '0;
            end

            DE                 <= de1_q;
            {RED, GREEN, BLUE} <= de1_q ? pix_rgb : 12'h000;
            LOCKED             <= (state_q == StLocked);
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Downstream stage of the HS/VS timing generator; consumes its HS and VS pulses on the same PIX_CLK.
- Recovers horizontal and vertical pixel position from sync edges and produces a registered test pattern (12-bit RGB) plus data-enable.
- Re-times HS/VS so sync, DE and RGB leave the block mutually aligned for the DAC/connector pins.
- Default timing is 800x600@72 (50 MHz pixel clock): 120-clock HS, 6-line VS.

Parameters:
- H_SYNC, 120, HS pulse width in clocks.
- H_BP, 64, horizontal back porch in clocks.
- H_ACTIVE, 800, visible pixels per line.
- V_SYNC, 6, VS pulse width in lines.
- V_BP, 23, vertical back porch in lines.
- V_ACTIVE, 600, visible lines per frame.
- BAR_W, 100, colour-bar width in pixels (H_ACTIVE/8).
- H_TIMEOUT, 2047, clocks without an HS rise before sync is declared lost.

Ports:
- PIX_CLK, in, 1, pixel clock, all logic on rising edge.
- RST, in, 1, synchronous active-high reset.
- HS, in, 1, horizontal sync from timing stage, active-high.
- VS, in, 1, vertical sync from timing stage, active-high.
- MODE, in, 2, pattern select: 0 bars, 1 checker, 2 gradient, 3 border.
- HS_OUT, out, 1, HS delayed 3 clocks.
- VS_OUT, out, 1, VS delayed 3 clocks.
- DE, out, 1, active-video enable.
- RED, out, 4, red channel.
- GREEN, out, 4, green channel.
- BLUE, out, 4, blue channel.
- LOCKED, out, 1, sync lock status.

Behaviour:
- **Reset:** synchronous, active-high; clock is PIX_CLK, reset is RST. While RST=1 at a clock edge, all of the following clear to 0: outputs, delay lines, hs_d, vs_d, counters, mode register; FSM goes to UNLOCKED. Reset mid-frame restarts acquisition.
- **Edge detect:** hs_d, vs_d are 1-clock registered copies of HS, VS. hs_rise = HS & ~hs_d; vs_rise = VS & ~vs_d.
- **hcnt (11 b):**
  - Loads 0 on the edge where hs_rise=1; otherwise increments.
  - Saturates at H_TIMEOUT and never wraps.
  - If HS rises at cycle t, hcnt=k at cycle t+1+k.
- **vcnt (10 b):**
  - Loads 0 on vs_rise.
  - Otherwise increments on hs_rise; saturates at 1023.
  - If vs_rise and hs_rise coincide, vs_rise wins (vcnt=0).
- **FSM:**
  - UNLOCKED: on hs_rise go to WAIT_VS.
  - WAIT_VS: on vs_rise go to LOCKED.
  - LOCKED: hcnt reaching H_TIMEOUT returns to UNLOCKED.
  - LOCKED output = state==LOCKED, registered.
- **Mode register:** MODE is captured only on vs_rise. Changes mid-frame take effect at the next frame. Reset value is 0.
- **Stage 1 (registered):**
  - de1 = LOCKED & (H_SYNC+H_BP ≤ hcnt < H_SYNC+H_BP+H_ACTIVE) & (V_SYNC+V_BP ≤ vcnt < V_SYNC+V_BP+V_ACTIVE).
  - x = hcnt−(H_SYNC+H_BP), 10 b; y = vcnt−(V_SYNC+V_BP), 10 b. Both are valid only when de1=1.
  - Bar logic, no divider:
    - bar_px counts 0..BAR_W−1 across active pixels and clears at line start.
    - bar_idx (3 b) increments when bar_px wraps.
- **Stage 2 (registered):** produces DE, RED, GREEN, BLUE. When de1=0, RGB=0.
  - Mode 0, bars: bar_idx 0..7 maps to {R,G,B} = 111, 110, 011, 010, 101, 100, 001, 000. Each bit expands to 4'hF or 4'h0.
  - Mode 1, checker: x[5]^y[5] selects FFF or 000.
  - Mode 2, gradient: R=G=B=x[9:6].
  - Mode 3, border: FFF when x==0, x==H_ACTIVE−1, y==0 or y==V_ACTIVE−1; else 000.
- **Alignment:**
  - HS_OUT and VS_OUT are HS and VS delayed by exactly 3 clocks.
  - DE first rises exactly H_SYNC+H_BP clocks after the HS_OUT rise, on line V_SYNC+V_BP after the VS_OUT rise.
  - Each DE-high run is exactly H_ACTIVE clocks long.
- **Loss of sync:**
  - Timeout forces LOCKED=0 and DE=0 within 2 clocks.
  - HS_OUT and VS_OUT keep following their inputs.

Test Plan:
1. Reset, then drive 800x600@72 timing (1040-clock line, 666-line frame) → LOCKED=1 after first HS then VS rise; DE low for whole first partial frame before lock.
2. Locked, MODE=0 → per active line DE high 800 clocks starting 184 clocks after HS_OUT rise; RGB=FFF for 100 clocks, then FF0, 0FF, 0F0, F0F, F00, 00F, 000; RGB=000 while DE=0.
3. MODE=1 and MODE=3 → pixel (32,0) is 000 and (31,0) is FFF in checker; border mode gives FFF at x=0, x=799, y=0, y=599 and 000 at (1,1).
4. Change MODE 0→2 mid-frame (line 300) → pattern stays bars to frame end; next frame shows gradient with pixel x=64 → RGB=111.
5. Hold HS low 2047+ clocks → LOCKED falls, DE=0, RGB=000; resume timing → relock after next HS then VS rise.
6. Assert RST for 1 clock mid-active-line → next edge: all outputs 0, FSM UNLOCKED; no DE until full reacquisition.
